// File: rtl/display_frame_buffer.sv
// display_frame_buffer: double-buffered 8-digit 7-segment frame store.
// Writes are staged and committed to the active digits only at a scan
// wrap (seg_sel 7->0) or after COMMIT_TIMEOUT cycles if scanning stalls.
// The selected digit is decoded combinationally to active-low cathodes.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   wr_en, wr_data      write request and 8 packed hex nibbles
//   wr_dp, wr_blank     per-digit decimal point enable / blank mask
//   seg_sel             digit currently scanned by the scan controller
//   wr_busy             staged update waiting for commit
//   wr_done, wr_drop    one-cycle pulses: commit happened / write refused
//   seg, dp             active-low cathodes {a..g} and decimal point
module display_frame_buffer #(
   parameter logic [31:0] RESET_DATA     = 32'h0000_0000,
   parameter int unsigned COMMIT_TIMEOUT = 1024,
   parameter int unsigned TW             = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic [7:0]  wr_dp,
   input  logic [7:0]  wr_blank,
   input  logic [2:0]  seg_sel,
   output logic        wr_busy,
   output logic        wr_done,
   output logic        wr_drop,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [TW-1:0] CNT_LAST = TW'(COMMIT_TIMEOUT - 1);
   localparam logic [TW-1:0] CNT_MAX  = TW'(COMMIT_TIMEOUT);

   typedef enum logic {ST_IDLE, ST_PEND} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] count, count_nx;
   logic          done_nx, drop_nx;
   logic [2:0]    prev_sel;
   logic [31:0]   stage_data, active_data;
   logic [7:0]    stage_dp, stage_blank, active_dp, active_blank;
   logic          frame_edge, accept, commit;
   logic [3:0]    nib;

   assign frame_edge = (prev_sel == 3'b111) && (seg_sel == 3'b000);
   assign accept     = (state == ST_IDLE) && wr_en;
   // boundary and timeout may coincide; either alone triggers the single commit
   assign commit     = (state == ST_PEND) && (frame_edge || (count == CNT_LAST));
   assign wr_busy    = (state == ST_PEND);

   // next-state, timeout counter and pulse generation
   always_comb begin
      state_nx = state;
      count_nx = count;
      done_nx  = 1'b0;
      drop_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wr_en) begin
               state_nx = ST_PEND;
               count_nx = '0;
            end
         end
         ST_PEND: begin
            // a write in the commit cycle is still refused
            drop_nx = wr_en;
            if (commit) begin
               state_nx = ST_IDLE;
               count_nx = '0;
               done_nx  = 1'b1;
            end else if (count != CNT_MAX) begin
               count_nx = count + TW'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // control state, pulses and scan history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         wr_done  <= 1'b0;
         wr_drop  <= 1'b0;
         prev_sel <= 3'b000;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         wr_done  <= done_nx;
         wr_drop  <= drop_nx;
         prev_sel <= seg_sel;
      end
   end

   // staging and active frame registers; active updates atomically
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_data   <= '0;
         stage_dp     <= '0;
         stage_blank  <= '0;
         active_data  <= RESET_DATA;
         active_dp    <= '0;
         active_blank <= '0;
      end else begin
         if (accept) begin
            stage_data  <= wr_data;
            stage_dp    <= wr_dp;
            stage_blank <= wr_blank;
         end
         if (commit) begin
            active_data  <= stage_data;
            active_dp    <= stage_dp;
            active_blank <= stage_blank;
         end
      end
   end

   assign nib = active_data[{seg_sel, 2'b00} +: 4];

   // zero-latency digit decode, active-low {a,b,c,d,e,f,g}
   always_comb begin
      seg = 7'b1111111;
      dp  = 1'b1;
      if (!active_blank[seg_sel]) begin
         dp = ~active_dp[seg_sel];
         case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
         endcase
      end
   end

endmodule
